// File: rtl/mem_monitor_pkg.sv
// Shared types for the memory-write monitor: FSM state and count-width helper.
package mem_monitor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} mon_state_t;

  // Bits needed to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mon_expect_buf.sv
// Expected (address, data) list: append-only register array with indexed read.
module mon_expect_buf import mem_monitor_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CW-1:0]     rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     entries,
  output logic              full
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CW-1:0]     wr_ptr;
  logic              push;

  // The list is append-only, so the write pointer doubles as the entry count.
  assign entries = wr_ptr;
  assign full    = (wr_ptr == CW'(DEPTH));
  assign push    = wr_en && !full && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      wr_ptr <= '0;
    else if (clear) wr_ptr <= '0;
    else if (push)  wr_ptr <= wr_ptr + 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end else if (push && wr_ptr == CW'(i)) begin
        addr_q[i] <= wr_addr;
        data_q[i] <= wr_data;
      end
    end
  end

  // Out-of-range index (list fully matched) reads as zero.
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == CW'(i)) begin
        rd_addr = addr_q[i];
        rd_data = data_q[i];
      end
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// Snoops CPU stores and checks them against a programmed list of expected writes.
module mem_write_monitor import mem_monitor_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  parameter int ORDERED = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memwrite,
  input  logic [ADDR_W-1:0]       dataadr,
  input  logic [DATA_W-1:0]       writedata,
  input  logic                    exp_valid,
  input  logic [ADDR_W-1:0]       exp_addr,
  input  logic [DATA_W-1:0]       exp_data,
  output logic                    exp_ready,
  input  logic                    start,
  input  logic                    clear,
  output logic                    pass,
  output logic                    fail,
  output logic [cnt_w(DEPTH)-1:0] match_count,
  output logic [15:0]             write_count,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [DATA_W-1:0]       err_data
);

  localparam int CW = cnt_w(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  mon_state_t        state_q, state_d;
  logic [CW-1:0]     mc_d, mc_inc, entries;
  logic [15:0]       wc_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [ADDR_W-1:0] ea_d, rd_addr;
  logic [DATA_W-1:0] ed_d, rd_data;
  logic              full, hit;

  assign exp_ready = (state_q == IDLE) && !full;
  assign pass      = (state_q == PASS);
  assign fail      = (state_q == FAIL);

  mon_expect_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk), .reset(reset), .clear(clear),
    .wr_en(exp_valid && exp_ready),
    .wr_addr(exp_addr), .wr_data(exp_data),
    .rd_idx(match_count), .rd_addr(rd_addr), .rd_data(rd_data),
    .entries(entries), .full(full)
  );

  assign hit    = memwrite && dataadr == rd_addr && writedata == rd_data;
  assign mc_inc = match_count + 1'b1;

  always_comb begin
    state_d = state_q;
    mc_d    = match_count;
    wc_d    = write_count;
    tmr_d   = tmr_q;
    ea_d    = err_addr;
    ed_d    = err_data;
    if (clear) begin
      state_d = IDLE;
      mc_d    = '0;
      wc_d    = '0;
      tmr_d   = '0;
      ea_d    = '0;
      ed_d    = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = RUN;
          mc_d    = '0;
          wc_d    = '0;
          tmr_d   = '0;
          ea_d    = '0;
          ed_d    = '0;
        end
        RUN: begin
          if (memwrite && write_count != 16'hFFFF) wc_d = write_count + 16'd1;
          // A match is tested before the timeout so a last-cycle hit still passes.
          if (entries == '0) begin
            state_d = PASS;
          end else if (hit) begin
            mc_d  = mc_inc;
            tmr_d = '0;
            if (mc_inc == entries) state_d = PASS;
          end else if (memwrite && ORDERED != 0) begin
            state_d = FAIL;
            ea_d    = dataadr;
            ed_d    = writedata;
          end else if (tmr_q == TW'(TIMEOUT - 1)) begin
            state_d = FAIL;
            ea_d    = '0;
            ed_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      match_count <= '0;
      write_count <= '0;
      tmr_q       <= '0;
      err_addr    <= '0;
      err_data    <= '0;
    end else begin
      state_q     <= state_d;
      match_count <= mc_d;
      write_count <= wc_d;
      tmr_q       <= tmr_d;
      err_addr    <= ea_d;
      err_data    <= ed_d;
    end
  end

endmodule

// File: doc/mem_write_monitor.md
# mem_write_monitor

Parametrised memory-write scoreboard for simulation benches and on-chip self-test of the `mips_cpu` data port. It snoops the CPU's `memwrite`/`dataadr`/`writedata` bus and compares writes against a programmed list of expected (address, data) pairs. It asserts `pass` once every expected write has been seen, or `fail` on a mismatch (ordered mode) or on a watchdog timeout. It replaces hard-coded single-pair stop checks with a reusable, depth- and width-configurable checker.

## Interface
- `ADDR_W`, 32, width of `dataadr` and expected addresses
- `DATA_W`, 32, width of `writedata` and expected data
- `DEPTH`, 8, maximum number of expected entries (≥1)
- `TIMEOUT`, 1000, max cycles in RUN without a matching write before `fail` (≥1)
- `ORDERED`, 1, 1 = writes must match list in order, any other write fails; 0 = non-matching writes ignored
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `memwrite`  in  1  snooped CPU store strobe
- `dataadr`  in  ADDR_W  snooped store address
- `writedata`  in  DATA_W  snooped store data
- `exp_valid`  in  1  expected-entry load request
- `exp_addr`  in  ADDR_W  expected address
- `exp_data`  in  DATA_W  expected data
- `exp_ready`  out  1  entry accepted when `exp_valid && exp_ready`
- `start`  in  1  pulse: IDLE → RUN
- `clear`  in  1  pulse: any state → IDLE, list emptied
- `pass`  out  1  all expected writes matched
- `fail`  out  1  mismatch or timeout
- `match_count`  out  $clog2(DEPTH+1)  entries matched so far
- `write_count`  out  16  total writes snooped in RUN, saturating at 16'hFFFF
- `err_addr`  out  ADDR_W  address of the failing write (0 on timeout)
- `err_data`  out  DATA_W  data of the failing write (0 on timeout)

## Operation
- States: IDLE, RUN, PASS, FAIL.
- IDLE: `exp_ready = (entries < DEPTH)`. An accepted entry is appended at `wr_ptr`. `start` → RUN and clears `match_count`, `write_count`, and the timer. Bus writes are ignored.
- RUN: `exp_ready = 0`. On each edge with `memwrite=1`, the write is compared to entry[`match_count`]:
  - Match: increment `match_count`, reset the timer. When `match_count` reaches `entries` → PASS.
  - Mismatch with ORDERED=1: → FAIL and latch `err_addr`/`err_data`.
  - Mismatch with ORDERED=0: no effect beyond `write_count`.
- Timer increments every RUN cycle without a match. Reaching TIMEOUT → FAIL with `err_*` = 0.
- Same-edge match and timeout: the match wins.
- Started with 0 entries: RUN → PASS on the next edge.
- PASS/FAIL are sticky until `clear` or `reset`. The list is retained, so `start` from PASS/FAIL is ignored. `clear` returns to IDLE with entries = 0.
- `clear` has priority over `start` and over `exp_valid`.
- Reset values: state IDLE, entries 0, `pass=0`, `fail=0`, `match_count=0`, `write_count=0`, `err_addr=0`, `err_data=0`, `exp_ready=1`.
- Reset mid-RUN aborts immediately. The list contents are lost.

## Timing
- `pass`, `fail`, `match_count`, and `err_*` are registered. They reflect a write sampled at edge N from edge N onward, i.e. they are visible in the cycle after the write cycle.
- A write presented in the same cycle as `start` is not checked. RUN begins on the following edge.
- Entry load: zero latency. Accepted on the edge where the handshake holds, and usable by a `start` on the next cycle.
- `exp_ready` is combinational from state and entry count only.
- The timer counts edges spent in RUN. With no writes, `fail` rises exactly TIMEOUT edges after RUN entry.

## Structure
- `mem_monitor_pkg`: state enum `mon_state_t` (IDLE, RUN, PASS, FAIL) and a function computing the count width.
- Sub-module `mon_expect_buf`: DEPTH×(ADDR_W+DATA_W) register array with write pointer, entry count, and combinational read at index. The top holds the FSM, timer, and counters.

## Test plan
- Load (84,7), start, drive store 84←7 → `pass=1` next cycle, `match_count=1`, `fail=0`.
- ORDERED=1, load (80,5),(84,7), drive 84←7 first → `fail=1`, `err_addr=84`, `err_data=7`, `match_count=0`.
- ORDERED=0, same list, drive 60←3, 80←5, 84←7 → `pass=1`, `write_count=3`, `match_count=2`.
- TIMEOUT=20, load one entry, start, no writes → `fail` rises exactly 20 edges after RUN entry, `err_*`=0.
- Load DEPTH entries → `exp_ready=0`, an extra `exp_valid` is not stored. `clear` → `exp_ready=1`, entries 0. `start` → `pass` next cycle.
- Assert `reset` in RUN after 1 of 2 matches → all outputs return to reset values immediately (asynchronous). `start` afterwards → `pass` (empty list).
